mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 147 ++++++++++++++
 tb/tb_mem_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_stage                                                     |
// | Purpose  : Pipeline MEM stage. Issues one data-memory request per load   |
// |            or store, stalls upstream while the memory is busy, bounds    |
// |            the wait with a timeout, flags illegal/timed-out accesses and |
// |            registers the MEM/WB pipeline outputs.                        |
// | Ports    : clk_i, rst_i (async, active-low)                              |
// |            wb_i/m_i/alu_i/mux7_i/mux3_i   - EX/MEM inputs                |
// |            mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o,                    |
// |            mem_ack_i/mem_rdata_i          - data-memory handshake        |
// |            stall_o                        - hold EX/MEM and earlier      |
// |            wb_o/alu_o/rdata_o/rd_o        - registered MEM/WB outputs    |
// |            err_o                          - sticky access-error flag     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_stage #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  wb_i,
   input  logic [1:0]  m_i,
   input  logic [31:0] alu_i,
   input  logic [31:0] mux7_i,
   input  logic [4:0]  mux3_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        stall_o,
   output logic [1:0]  wb_o,
   output logic [31:0] alu_o,
   output logic [31:0] rdata_o,
   output logic [4:0]  rd_o,
   output logic        err_o
);

   // Last wait-counter value before the access is abandoned.
   localparam logic [9:0] c_WAIT_LAST = 10'(MAX_WAIT - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [9:0]  r_wait_cnt;

   logic        w_one_op;
   logic        w_valid;
   logic        w_illegal;
   logic        w_req;
   logic        w_timeout;
   logic        w_read_ack;
   logic        w_err_evt;

   // Exactly one of MemRead/MemWrite, word aligned.
   assign w_one_op  = m_i[1] ^ m_i[0];
   assign w_valid   = w_one_op && (alu_i[1:0] == 2'b00);
   assign w_illegal = (m_i == 2'b11) || ((m_i != 2'b00) && (alu_i[1:0] != 2'b00));

   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_req = w_valid;
            if (w_valid && !mem_ack_i) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            w_req     = 1'b1;
            // An ack on the last wait cycle wins over the timeout.
            w_timeout = (r_wait_cnt == c_WAIT_LAST) && !mem_ack_i;
            if (mem_ack_i || w_timeout) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // The request is gated by reset so it drops the instant reset asserts,
   // even though the state register is only cleared through its async path.
   assign mem_req_o   = w_req && rst_i;
   assign mem_we_o    = m_i[0];
   assign mem_addr_o  = alu_i;
   assign mem_wdata_o = mux7_i;
   assign stall_o     = mem_req_o && !mem_ack_i && !w_timeout;

   // Acks are only meaningful while a request is outstanding.
   assign w_read_ack  = mem_req_o && mem_ack_i && m_i[1];
   assign w_err_evt   = ((r_state == S_IDLE) && w_illegal) || w_timeout;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_wait_cnt <= 10'd0;
      end else if ((r_state == S_IDLE) && (w_state_nxt == S_WAIT)) begin
         r_wait_cnt <= 10'd0;
      end else if ((r_state == S_WAIT) && !mem_ack_i) begin
         r_wait_cnt <= r_wait_cnt + 10'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wb_o    <= 2'b00;
         alu_o   <= 32'd0;
         rdata_o <= 32'd0;
         rd_o    <= 5'd0;
      end else if (stall_o) begin
         // Bubble into WB while the access is outstanding.
         wb_o    <= 2'b00;
      end else begin
         wb_o    <= wb_i;
         alu_o   <= alu_i;
         rd_o    <= mux3_i;
         rdata_o <= w_read_ack ? mem_rdata_i : 32'd0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         err_o <= 1'b0;
      end else if (w_err_evt) begin
         err_o <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_stage                                                  |
// | Purpose  : Self-checking bench for mem_stage (MAX_WAIT=4). A directed    |
// |            stimulus process queues the expected MEM/WB result of each    |
// |            instruction; a monitor pops and compares whenever the DUT     |
// |            presents a completed instruction (wb_o != 0).                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mem_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  wb_i;
   logic [1:0]  m_i;
   logic [31:0] alu_i;
   logic [31:0] mux7_i;
   logic [4:0]  mux3_i;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        stall_o;
   logic [1:0]  wb_o;
   logic [31:0] alu_o;
   logic [31:0] rdata_o;
   logic [4:0]  rd_o;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0]  wb;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [4:0]  rd;
      logic        err;
   } exp_t;

   exp_t sb_q[$];

   mem_stage #(.MAX_WAIT(4)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .wb_i        (wb_i),
      .m_i         (m_i),
      .alu_i       (alu_i),
      .mux7_i      (mux7_i),
      .mux3_i      (mux3_i),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rdata_i (mem_rdata_i),
      .stall_o     (stall_o),
      .wb_o        (wb_o),
      .alu_o       (alu_o),
      .rdata_o     (rdata_o),
      .rd_o        (rd_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_nop();
      wb_i = 2'b00; m_i = 2'b00; alu_i = 32'd0; mux7_i = 32'd0; mux3_i = 5'd0;
      mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
   endtask

   // Issue one instruction. ack_at = request cycle (1-based) carrying the ack,
   // 0 = never. Entered and left at posedge+1.
   task automatic access(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd, input int ack_at,
                         input logic [31:0] rdat, input logic exp_req, input int exp_stalls,
                         input logic [31:0] exp_rdata, input logic exp_err);
      int   cyc;
      int   nstall;
      logic s;
      exp_t e;
      e.wb = wb; e.alu = alu; e.rdata = exp_rdata; e.rd = rd; e.err = exp_err;
      sb_q.push_back(e);
      wb_i = wb; m_i = m; alu_i = alu; mux7_i = wd; mux3_i = rd; mem_rdata_i = rdat;
      nstall = 0;
      cyc    = 1;
      forever begin
         mem_ack_i = (cyc == ack_at);
         @(negedge clk_i);
         chk("mem_req", {63'd0, mem_req_o}, {63'd0, exp_req});
         if (exp_req && cyc == 1) begin
            chk("mem_we", {63'd0, mem_we_o}, {63'd0, m[0]});
            chk("mem_addr", {32'd0, mem_addr_o}, {32'd0, alu});
            chk("mem_wdata", {32'd0, mem_wdata_o}, {32'd0, wd});
         end
         if (cyc > 1) chk("wb_bubble", {62'd0, wb_o}, 64'd0);
         s = stall_o;
         if (s) nstall++;
         @(posedge clk_i);
         #1;
         if (!s) break;
         cyc++;
         if (cyc > 20) begin
            chk("stall_bound", 64'd1, 64'd0);
            break;
         end
      end
      chk("stall_cycles", 64'(nstall), 64'(exp_stalls));
      drive_nop();
      @(posedge clk_i);
      #1;
   endtask

   // Monitor: every cycle in which a completed instruction is on MEM/WB.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (rst_i === 1'b1 && wb_o != 2'b00) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_completion", {62'd0, wb_o}, 64'd0);
            end else begin
               e = sb_q.pop_front();
               chk("wb_o", {62'd0, wb_o}, {62'd0, e.wb});
               chk("alu_o", {32'd0, alu_o}, {32'd0, e.alu});
               chk("rdata_o", {32'd0, rdata_o}, {32'd0, e.rdata});
               chk("rd_o", {59'd0, rd_o}, {59'd0, e.rd});
               chk("err_o", {63'd0, err_o}, {63'd0, e.err});
            end
         end
      end
   end

   initial begin
      drive_nop();
      rst_i = 1'b0;
      // Valid load presented during reset must not produce a request.
      m_i = 2'b10; alu_i = 32'h40; wb_i = 2'b11;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_req", {63'd0, mem_req_o}, 64'd0);
      chk("rst_stall", {63'd0, stall_o}, 64'd0);
      chk("rst_outs", {wb_o, alu_o, rd_o, err_o}, 64'd0);
      chk("rst_rdata", {32'd0, rdata_o}, 64'd0);
      drive_nop();
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Zero-wait load.
      access(2'b11, 2'b10, 32'h40, 32'h0, 5'd5, 1, 32'hDEADBEEF, 1'b1, 0, 32'hDEADBEEF, 1'b0);
      // Load with 3 wait cycles.
      access(2'b11, 2'b10, 32'h80, 32'h0, 5'd6, 4, 32'hCAFEF00D, 1'b1, 3, 32'hCAFEF00D, 1'b0);
      // Store, ack after 1 cycle; read bus garbage must not reach rdata_o.
      access(2'b01, 2'b01, 32'h100, 32'h12345678, 5'd0, 2, 32'hFFFFFFFF, 1'b1, 1, 32'h0, 1'b0);
      // Non-memory op with stray ack and odd address: no request, no error.
      access(2'b10, 2'b00, 32'h7, 32'h0, 5'd3, 1, 32'hAAAA5555, 1'b0, 0, 32'h0, 1'b0);
      // Ack on the timeout cycle: normal completion.
      access(2'b11, 2'b10, 32'h200, 32'h0, 5'd7, 5, 32'h0BADF00D, 1'b1, 4, 32'h0BADF00D, 1'b0);

      // Reset during WAIT abandons the access.
      wb_i = 2'b11; m_i = 2'b10; alu_i = 32'h300; mux3_i = 5'd9; mem_ack_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("pre_rst_stall", {63'd0, stall_o}, 64'd1);
      #2;
      rst_i = 1'b0;
      #1;
      chk("midrst_req", {63'd0, mem_req_o}, 64'd0);
      chk("midrst_stall", {63'd0, stall_o}, 64'd0);
      chk("midrst_outs", {wb_o, alu_o, rd_o, err_o}, 64'd0);
      chk("midrst_rdata", {32'd0, rdata_o}, 64'd0);
      drive_nop();
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      // Next access proceeds normally.
      access(2'b11, 2'b10, 32'h44, 32'h0, 5'd10, 2, 32'h55AA55AA, 1'b1, 1, 32'h55AA55AA, 1'b0);
      // Timeout with no ack: 4 stall cycles, rdata 0, error.
      access(2'b11, 2'b10, 32'h48, 32'h0, 5'd11, 0, 32'h13572468, 1'b1, 4, 32'h0, 1'b1);
      chk("err_sticky_idle", {63'd0, err_o}, 64'd1);

      // Clear the error with a short reset pulse.
      #2;
      rst_i = 1'b0;
      #2;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("err_cleared", {63'd0, err_o}, 64'd0);

      // Misaligned store: no request, no stall, error set.
      access(2'b01, 2'b01, 32'h102, 32'h87654321, 5'd0, 1, 32'h0, 1'b0, 0, 32'h0, 1'b1);
      // Error stays set across a good zero-wait load.
      access(2'b11, 2'b10, 32'h4C, 32'h0, 5'd12, 1, 32'h01020304, 1'b1, 0, 32'h01020304, 1'b1);
      // Both MemRead and MemWrite: illegal, no request.
      access(2'b11, 2'b11, 32'h50, 32'h0, 5'd13, 1, 32'hFEEDFACE, 1'b0, 0, 32'h0, 1'b1);

      repeat (3) @(posedge clk_i);
      #1;
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
